// File: rtl/mod_inverse_pkg.sv
// ============================================================================
//  Module : mod_inverse_pkg
//  Brief  : Shared state encoding, default sizes and width helper for the
//           sequential modular-inverse coprocessor.
//  Rev    : 1.0
// ============================================================================
`default_nettype none

package mod_inverse_pkg;

    localparam int DEFAULT_WIDTH  = 8;
    localparam int DEFAULT_STEP_W = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        ITER = 2'd2,
        DONE = 2'd3
    } state_t;

    // Bezout coefficients satisfy |t| <= m, so one extra sign bit suffices.
    function automatic int t_width(input int width);
        return width + 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mod_inverse_seq_if.sv
// ============================================================================
//  Module : mod_inverse_seq_if
//  Brief  : start/ready/valid request and result bundle for mod_inverse_seq.
//  Rev    : 1.0
// ============================================================================
`default_nettype none

interface mod_inverse_seq_if
    import mod_inverse_pkg::*;
#(
    parameter int WIDTH  = DEFAULT_WIDTH,
    parameter int STEP_W = DEFAULT_STEP_W
);

    logic              start;
    logic [WIDTH-1:0]  modulus;
    logic [WIDTH-1:0]  a;
    logic              ready;
    logic              busy;
    logic              valid;
    logic [WIDTH-1:0]  inverse;
    logic              no_inverse;
    logic [STEP_W-1:0] steps;

    modport master (
        output start, modulus, a,
        input  ready, busy, valid, inverse, no_inverse, steps
    );

    modport slave (
        input  start, modulus, a,
        output ready, busy, valid, inverse, no_inverse, steps
    );

endinterface

`default_nettype wire

// File: rtl/euclid_div_step.sv
// ============================================================================
//  Module : euclid_div_step
//  Brief  : One combinational extended-Euclid division step on (r0,r1,t0,t1).
//  Rev    : 1.0
// ============================================================================
`default_nettype none

module euclid_div_step
    import mod_inverse_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int TW    = WIDTH + 1
) (
    input  logic [WIDTH-1:0]        r0,
    input  logic [WIDTH-1:0]        r1,
    input  logic signed [TW-1:0]    t0,
    input  logic signed [TW-1:0]    t1,
    output logic [WIDTH-1:0]        r0_next,
    output logic [WIDTH-1:0]        r1_next,
    output logic signed [TW-1:0]    t0_next,
    output logic signed [TW-1:0]    t1_next
);

    logic [WIDTH-1:0]     q;
    logic signed [TW-1:0] q_s;

    // The caller never uses the result when r1 is zero; the guard keeps X out.
    assign q   = (r1 == '0) ? '0 : r0 / r1;
    assign q_s = $signed({1'b0, q});

    assign r0_next = r1;
    assign r1_next = r0 - q * r1;
    assign t0_next = t1;
    // Intermediate product may wrap; the true difference always fits in TW bits.
    assign t1_next = t0 - q_s * t1;

endmodule

`default_nettype wire

// File: rtl/mod_inverse_seq.sv
// ============================================================================
//  Module : mod_inverse_seq
//  Brief  : Multi-cycle a^-1 mod m via extended Euclid, one step per clock.
//  Rev    : 1.0
// ============================================================================
`default_nettype none

module mod_inverse_seq
    import mod_inverse_pkg::*;
#(
    parameter int WIDTH  = DEFAULT_WIDTH,
    parameter int STEP_W = DEFAULT_STEP_W
) (
    input  logic              clk,
    input  logic              rst,
    mod_inverse_seq_if.slave  bus
);

    localparam int TW = t_width(WIDTH);

    state_t               state, state_next;
    logic                 accept;
    logic [WIDTH-1:0]     m_q, a_q;
    logic [WIDTH-1:0]     r0, r1, r0_nx, r1_nx;
    logic signed [TW-1:0] t0, t1, t0_nx, t1_nx;
    logic signed [TW-1:0] t_norm;
    logic                 bad;
    logic                 m_small;
    logic [WIDTH-1:0]     inverse_q;
    logic                 no_inv_q;
    logic [STEP_W-1:0]    steps_q;

    euclid_div_step #(.WIDTH(WIDTH), .TW(TW)) u_step (
        .r0      (r0),
        .r1      (r1),
        .t0      (t0),
        .t1      (t1),
        .r0_next (r0_nx),
        .r1_next (r1_nx),
        .t0_next (t0_nx),
        .t1_next (t1_nx)
    );

    assign m_small = (m_q < WIDTH'(2));
    assign t_norm  = t0[TW-1] ? (t0 + $signed({1'b0, m_q})) : t0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next     = state;
        accept         = 1'b0;
        bus.ready      = 1'b0;
        bus.busy       = 1'b0;
        bus.valid      = 1'b0;
        bus.inverse    = inverse_q;
        bus.no_inverse = no_inv_q;
        bus.steps      = steps_q;
        case (state)
            IDLE: begin
                bus.ready = 1'b1;
                if (bus.start) begin
                    accept     = 1'b1;
                    state_next = LOAD;
                end
            end
            LOAD: begin
                bus.busy   = 1'b1;
                state_next = ITER;
            end
            ITER: begin
                bus.busy = 1'b1;
                if (r1 == '0) state_next = DONE;
            end
            DONE: begin
                bus.valid  = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_q       <= '0;
            a_q       <= '0;
            r0        <= '0;
            r1        <= '0;
            t0        <= '0;
            t1        <= '0;
            bad       <= 1'b0;
            inverse_q <= '0;
            no_inv_q  <= 1'b0;
            steps_q   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        m_q       <= bus.modulus;
                        a_q       <= bus.a;
                        bad       <= 1'b0;
                        inverse_q <= '0;
                        no_inv_q  <= 1'b0;
                        steps_q   <= '0;
                    end
                end
                LOAD: begin
                    r0 <= m_q;
                    t0 <= '0;
                    t1 <= {{(TW-1){1'b0}}, 1'b1};
                    // m<2 has no inverse and must not reach the divider.
                    if (m_small) begin
                        r1  <= '0;
                        bad <= 1'b1;
                    end else begin
                        r1  <= a_q % m_q;
                        bad <= 1'b0;
                    end
                end
                ITER: begin
                    if (r1 != '0) begin
                        r0 <= r0_nx;
                        r1 <= r1_nx;
                        t0 <= t0_nx;
                        t1 <= t1_nx;
                        if (steps_q != '1) steps_q <= steps_q + 1'b1;
                    end else if (!bad && r0 == WIDTH'(1)) begin
                        inverse_q <= t_norm[WIDTH-1:0];
                        no_inv_q  <= 1'b0;
                    end else begin
                        inverse_q <= '0;
                        no_inv_q  <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mod_inverse_seq.sv
// ============================================================================
//  Module : tb_mod_inverse_seq
//  Brief  : Directed and swept self-checking bench for mod_inverse_seq.
//  Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_mod_inverse_seq;

    logic clk;
    logic rst;
    int   checks;
    int   failures;
    int   lat;
    int   exp_inv;
    logic seen_valid;

    mod_inverse_seq_if #(.WIDTH(8), .STEP_W(5)) bus ();

    mod_inverse_seq #(.WIDTH(8), .STEP_W(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int ref_inverse(input int m, input int av);
        for (int x = 0; x < m; x++)
            if (((av * x) % m) == 1) return x;
        return -1;
    endfunction

    // Called at the negedge after the accept edge; returns edges-to-valid.
    task automatic wait_valid(output int cnt);
        cnt = 0;
        while (!bus.valid && cnt < 100) begin
            @(negedge clk);
            cnt++;
        end
        check_value("valid_seen", 32'(bus.valid), 32'd1);
    endtask

    task automatic run_op(input logic [7:0] m, input logic [7:0] av, output int cnt);
        @(negedge clk);
        bus.start   = 1'b1;
        bus.modulus = m;
        bus.a       = av;
        @(posedge clk);
        @(negedge clk);
        bus.start   = 1'b0;
        bus.modulus = 8'($urandom);
        bus.a       = 8'($urandom);
        wait_valid(cnt);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        checks      = 0;
        failures    = 0;
        rst         = 1'b1;
        bus.start   = 1'b0;
        bus.modulus = '0;
        bus.a       = '0;
        #3;
        check_value("rst_ready", 32'(bus.ready), 32'd1);
        check_value("rst_busy", 32'(bus.busy), 32'd0);
        check_value("rst_valid", 32'(bus.valid), 32'd0);
        check_value("rst_inverse", 32'(bus.inverse), 32'd0);
        check_value("rst_no_inv", 32'(bus.no_inverse), 32'd0);
        check_value("rst_steps", 32'(bus.steps), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // 5,3: three steps, valid five edges after accept
        run_op(8'd5, 8'd3, lat);
        check_value("m5_lat", 32'(lat), 32'd5);
        check_value("m5_inv", 32'(bus.inverse), 32'd2);
        check_value("m5_no_inv", 32'(bus.no_inverse), 32'd0);
        check_value("m5_steps", 32'(bus.steps), 32'd3);
        @(negedge clk);
        check_value("m5_pulse", 32'(bus.valid), 32'd0);
        check_value("m5_hold", 32'(bus.inverse), 32'd2);
        check_value("m5_ready", 32'(bus.ready), 32'd1);

        // Back-to-back with start held through DONE
        bus.start   = 1'b1;
        bus.modulus = 8'd13;
        bus.a       = 8'd11;
        @(posedge clk);
        @(negedge clk);
        bus.modulus = 8'd7;
        bus.a       = 8'd10;
        check_value("b2b_clear", 32'(bus.inverse), 32'd0);
        check_value("b2b_busy", 32'(bus.busy), 32'd1);
        wait_valid(lat);
        check_value("m13_inv", 32'(bus.inverse), 32'd6);
        check_value("m13_steps", 32'(bus.steps), 32'd3);
        @(negedge clk);
        check_value("b2b_idle_ready", 32'(bus.ready), 32'd1);
        @(negedge clk);
        bus.start = 1'b0;
        check_value("b2b_accepted", 32'(bus.busy), 32'd1);
        wait_valid(lat);
        check_value("m7_inv", 32'(bus.inverse), 32'd5);
        check_value("m7_steps", 32'(bus.steps), 32'd2);
        check_value("m7_no_inv", 32'(bus.no_inverse), 32'd0);

        run_op(8'd12, 8'd8, lat);
        check_value("m12_no_inv", 32'(bus.no_inverse), 32'd1);
        check_value("m12_inv", 32'(bus.inverse), 32'd0);
        check_value("m12_steps", 32'(bus.steps), 32'd2);

        run_op(8'd9, 8'd0, lat);
        check_value("m9_no_inv", 32'(bus.no_inverse), 32'd1);
        check_value("m9_lat", 32'(lat), 32'd2);

        run_op(8'd1, 8'd5, lat);
        check_value("m1_no_inv", 32'(bus.no_inverse), 32'd1);
        check_value("m1_inv", 32'(bus.inverse), 32'd0);
        check_value("m1_lat", 32'(lat), 32'd2);

        run_op(8'd0, 8'd3, lat);
        check_value("m0_no_inv", 32'(bus.no_inverse), 32'd1);
        check_value("m0_inv", 32'(bus.inverse), 32'd0);
        check_value("m0_lat", 32'(lat), 32'd2);
        check_value("m0_steps", 32'(bus.steps), 32'd0);

        run_op(8'd255, 8'd254, lat);
        check_value("m255_inv", 32'(bus.inverse), 32'd254);
        check_value("m255_steps", 32'(bus.steps), 32'd2);

        // start pulsed while busy must neither disturb nor queue
        @(negedge clk);
        bus.start   = 1'b1;
        bus.modulus = 8'd5;
        bus.a       = 8'd3;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        bus.start   = 1'b1;
        bus.modulus = 8'd13;
        bus.a       = 8'd11;
        @(negedge clk);
        bus.start = 1'b0;
        wait_valid(lat);
        check_value("busy_ign_inv", 32'(bus.inverse), 32'd2);
        repeat (3) @(negedge clk);
        check_value("busy_ign_noq", 32'(bus.busy), 32'd0);

        // Asynchronous reset in the middle of ITER
        @(negedge clk);
        bus.start   = 1'b1;
        bus.modulus = 8'd13;
        bus.a       = 8'd11;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (2) @(negedge clk);
        check_value("pre_rst_steps", 32'(bus.steps), 32'd1);
        #2 rst = 1'b1;
        #1;
        check_value("arst_steps", 32'(bus.steps), 32'd0);
        check_value("arst_busy", 32'(bus.busy), 32'd0);
        check_value("arst_ready", 32'(bus.ready), 32'd1);
        seen_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (i == 2) rst = 1'b0;
            seen_valid = seen_valid | bus.valid;
        end
        check_value("arst_no_valid", 32'(seen_valid), 32'd0);
        run_op(8'd13, 8'd11, lat);
        check_value("post_rst_inv", 32'(bus.inverse), 32'd6);

        // Sweep against a brute-force reference
        for (int i = 0; i < 24; i++) begin
            automatic int m  = $urandom_range(2, 255);
            automatic int av = $urandom_range(0, 255);
            run_op(8'(m), 8'(av), lat);
            exp_inv = ref_inverse(m, av);
            if (exp_inv < 0) begin
                check_value("rnd_no_inv", 32'(bus.no_inverse), 32'd1);
                check_value("rnd_inv_zero", 32'(bus.inverse), 32'd0);
            end else begin
                check_value("rnd_no_inv", 32'(bus.no_inverse), 32'd0);
                check_value("rnd_inv", 32'(bus.inverse), 32'(exp_inv));
                check_value("rnd_prod", 32'((av * int'(bus.inverse)) % m), 32'd1);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
